// File: rtl/alu_if.sv
// Operand/opcode bundle and registered result for the dual-mode execute-stage ALU.
// The master drives operands and controls; the slave (the ALU) drives result.
interface alu_if;
  logic [63:0] a;
  logic [63:0] b;
  logic        mode;
  logic [2:0]  ALUOpA;
  logic [2:0]  ALUOpB;
  logic [5:0]  ALUCtrl;
  logic [63:0] result;

  modport master (
    output a, b, mode, ALUOpA, ALUOpB, ALUCtrl,
    input  result
  );

  modport slave (
    input  a, b, mode, ALUOpA, ALUOpB, ALUCtrl,
    output result
  );
endinterface

// File: rtl/alu.sv
// Dual-mode ALU: one 64-bit op (mode=1) or two independent 32-bit lane ops (mode=0).
// Result is captured on every rising clk edge; rst_n clears it asynchronously.
module alu (
  input  logic clk,
  input  logic rst_n,
  alu_if.slave bus
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_SHF = 3'b100;

  // The signed copy keeps >>> arithmetic; mixing it into a ternary with
  // unsigned operands would silently turn it into a logical shift.
  function automatic logic [31:0] lane_op(
    input logic [2:0]  op,
    input logic [31:0] x,
    input logic [31:0] y,
    input logic        sub_arith,
    input logic        dir_right
  );
    logic signed [31:0] sx;
    logic        [31:0] sra;
    logic        [31:0] r;
    sx  = x;
    sra = sx >>> y[4:0];
    r   = '0;
    case (op)
      OP_ADD: r = sub_arith ? (x - y) : (x + y);
      OP_AND: r = x & y;
      OP_OR:  r = x | y;
      OP_XOR: r = x ^ y;
      OP_SHF: begin
        if (!dir_right)     r = x << y[4:0];
        else if (sub_arith) r = sra;
        else                r = x >> y[4:0];
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [63:0] word_op(
    input logic [2:0]  op,
    input logic [63:0] x,
    input logic [63:0] y,
    input logic        sub_arith,
    input logic        dir_right
  );
    logic signed [63:0] sx;
    logic        [63:0] sra;
    logic        [63:0] r;
    sx  = x;
    sra = sx >>> y[5:0];
    r   = '0;
    case (op)
      OP_ADD: r = sub_arith ? (x - y) : (x + y);
      OP_AND: r = x & y;
      OP_OR:  r = x | y;
      OP_XOR: r = x ^ y;
      OP_SHF: begin
        if (!dir_right)     r = x << y[5:0];
        else if (sub_arith) r = sra;
        else                r = x >> y[5:0];
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  logic [63:0] result_d;
  logic [31:0] lo_res;
  logic [31:0] hi_res;

  // Each lane is computed in its own 32-bit function, so carries and shifted
  // bits cannot cross the lane boundary.
  always_comb begin
    lo_res   = lane_op(bus.ALUOpA, bus.a[31:0], bus.b[31:0],
                       bus.ALUCtrl[0], bus.ALUCtrl[1]);
    hi_res   = lane_op(bus.ALUOpB, bus.a[63:32], bus.b[63:32],
                       bus.ALUCtrl[2], bus.ALUCtrl[3]);
    result_d = {hi_res, lo_res};
    if (bus.mode) begin
      result_d = word_op(bus.ALUOpA, bus.a, bus.b,
                         bus.ALUCtrl[4], bus.ALUCtrl[5]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.result <= '0;
    end else begin
      bus.result <= result_d;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Directed bench for alu: a bit-level behavioural model feeds an expected queue
// checked every cycle, plus hand-computed literals for the reference vectors.
module tb_alu;

  logic clk;
  logic rst_n;
  alu_if bus ();

  alu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %016h expected %016h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // One lane of width w (32 or 64), built bit by bit from the operation rules.
  function automatic logic [63:0] model_lane(
    input logic [2:0]  op,
    input logic [63:0] x_in,
    input logic [63:0] y_in,
    input bit          sub_ar,
    input bit          dir_right,
    input int          w
  );
    logic [63:0] mask, x, y, r;
    int sh;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    x = x_in & mask;
    y = y_in & mask;
    sh = (w == 64) ? int'(y % 64) : int'(y % 32);
    r = '0;
    case (op)
      3'd0: r = sub_ar ? (x + ~y + 64'd1) : (x + y);
      3'd1: r = x & y;
      3'd2: r = x | y;
      3'd3: r = x ^ y;
      3'd4: begin
        for (int i = 0; i < w; i++) begin
          if (dir_right) begin
            if (i + sh < w) r[i] = x[i + sh];
            else            r[i] = sub_ar ? x[w - 1] : 1'b0;
          end else begin
            r[i] = (i >= sh) ? x[i - sh] : 1'b0;
          end
        end
      end
      default: r = '0;
    endcase
    return r & mask;
  endfunction

  function automatic logic [63:0] model(
    input logic [63:0] a, input logic [63:0] b, input logic m,
    input logic [2:0] opa, input logic [2:0] opb, input logic [5:0] c
  );
    logic [63:0] lo, hi;
    if (m) return model_lane(opa, a, b, c[4], c[5], 64);
    lo = model_lane(opa, a, b, c[0], c[1], 32);
    hi = model_lane(opb, a >> 32, b >> 32, c[2], c[3], 32);
    return (hi << 32) | lo;
  endfunction

  // ---------------- scoreboard ----------------
  always @(posedge clk) begin
    if (rst_n)
      exp_q.push_back(model(bus.a, bus.b, bus.mode, bus.ALUOpA, bus.ALUOpB, bus.ALUCtrl));
  end

  always @(negedge rst_n) exp_q.delete();

  always @(negedge clk) begin
    if (!rst_n)
      check("reset_hold", bus.result, 64'd0);
    else if (exp_q.size() > 0)
      check("model", bus.result, exp_q.pop_front());
  end

  // ---------------- driver ----------------
  task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic m,
                       input logic [2:0] opa, input logic [2:0] opb, input logic [5:0] c);
    @(negedge clk);
    #1;
    bus.a = a; bus.b = b; bus.mode = m;
    bus.ALUOpA = opa; bus.ALUOpB = opb; bus.ALUCtrl = c;
  endtask

  // Apply one vector and check it against a hand-computed literal, also pinning the model.
  task automatic apply_lit(input string name, input logic [63:0] a, input logic [63:0] b,
                           input logic m, input logic [2:0] opa, input logic [2:0] opb,
                           input logic [5:0] c, input logic [63:0] lit);
    drive(a, b, m, opa, opb, c);
    check({name, "_model"}, model(a, b, m, opa, opb, c), lit);
    @(posedge clk);
    #1;
    check(name, bus.result, lit);
  endtask

  task automatic apply(input logic [63:0] a, input logic [63:0] b, input logic m,
                       input logic [2:0] opa, input logic [2:0] opb, input logic [5:0] c);
    drive(a, b, m, opa, opb, c);
    @(posedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.a = '0; bus.b = '0; bus.mode = 1'b1;
    bus.ALUOpA = '0; bus.ALUOpB = '0; bus.ALUCtrl = '0;
    #3;
    check("reset_initial", bus.result, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    // Unified arithmetic and logic
    apply_lit("u_add", 64'd3, 64'd4, 1'b1, 3'b000, 3'b000, 6'b000000, 64'h7);
    apply_lit("u_sub", 64'd9, 64'd5, 1'b1, 3'b000, 3'b000, 6'b010000, 64'h4);
    apply_lit("u_and", 64'hFFFF0000FFFF0000, 64'h0F0FF0F00F0FF0F0, 1'b1, 3'b001, 3'b000,
              6'b000000, 64'h0F0F00000F0F0000);
    apply_lit("u_wrap", 64'hFFFFFFFFFFFFFFFF, 64'd1, 1'b1, 3'b000, 3'b000, 6'b000000, 64'h0);

    // Unified shifts
    apply_lit("u_shl", 64'hFF, 64'd4, 1'b1, 3'b100, 3'b000, 6'b000000, 64'hFF0);
    apply_lit("u_shr", 64'h8000000000000000, 64'd4, 1'b1, 3'b100, 3'b000, 6'b100000,
              64'h0800000000000000);
    apply_lit("u_sra", 64'h8000000000000000, 64'd4, 1'b1, 3'b100, 3'b000, 6'b110000,
              64'hF800000000000000);
    apply_lit("u_shl_arithbit", 64'hFF, 64'd4, 1'b1, 3'b100, 3'b000, 6'b010000, 64'hFF0);
    apply_lit("u_shift0", 64'h8123456789ABCDEF, 64'h40, 1'b1, 3'b100, 3'b000, 6'b110000,
              64'h8123456789ABCDEF);
    apply_lit("u_op_inv", 64'h1234, 64'h5678, 1'b1, 3'b101, 3'b000, 6'b000000, 64'h0);

    // Split logic, shift and sub
    apply_lit("s_add_and", 64'hFFFF0000_DEADBEEF, 64'h00000004_00000001, 1'b0, 3'b000, 3'b001,
              6'b000000, 64'h00000000_DEADBEF0);
    apply_lit("s_or_xor", 64'hFFFF0000_DEADBEEF, 64'h00000004_00000001, 1'b0, 3'b010, 3'b011,
              6'b000000, 64'hFFFF0004_DEADBEEF);
    apply_lit("s_shift", 64'hFFFF0000_DEADBEEF, 64'h00000004_00000001, 1'b0, 3'b100, 3'b100,
              6'b001100, 64'hFFFFF000_BD5B7DDE);
    apply_lit("s_sub", 64'hFFFF0000_DEADBEEF, 64'h00000004_00000001, 1'b0, 3'b000, 3'b000,
              6'b000100, 64'hFFFEFFFC_DEADBEF0);
    apply_lit("s_iso", 64'hFFFFFFFFFFFFFFFF, 64'd1, 1'b0, 3'b000, 3'b000, 6'b000000,
              64'hFFFFFFFF_00000000);
    apply_lit("s_lo_sra", 64'h00000001_80000000, 64'h00000001_0000001F, 1'b0, 3'b100, 3'b100,
              6'b000011, 64'h00000002_FFFFFFFF);
    apply_lit("s_lo_sub_borrow", 64'h00000005_00000000, 64'h00000000_00000001, 1'b0, 3'b000,
              3'b000, 6'b000001, 64'h00000005_FFFFFFFF);
    apply_lit("s_inv_ops", 64'h12345678_9ABCDEF0, 64'h11111111_22222222, 1'b0, 3'b111, 3'b110,
              6'b001111, 64'h0);
    apply_lit("s_ctrl_hi_ign", 64'h00000003_00000009, 64'h00000001_00000005, 1'b0, 3'b000,
              3'b000, 6'b110000, 64'h00000004_0000000E);

    // Model-only vectors: back-to-back mode and opcode changes
    apply(64'hA5A5A5A5_5A5A5A5A, 64'h0F0F0F0F_00FF00FF, 1'b1, 3'b011, 3'b000, 6'b000000);
    apply(64'hA5A5A5A5_5A5A5A5A, 64'h0F0F0F0F_00FF00FF, 1'b0, 3'b010, 3'b001, 6'b000000);
    apply(64'h80000000_00000001, 64'h00000003_0000001F, 1'b0, 3'b100, 3'b100, 6'b001010);
    apply(64'h8000000000000001, 64'd63, 1'b1, 3'b100, 3'b000, 6'b100000);
    apply(64'h8000000000000001, 64'd63, 1'b1, 3'b100, 3'b000, 6'b110000);
    apply(64'h8000000000000001, 64'd63, 1'b1, 3'b100, 3'b000, 6'b000000);
    apply(64'h0000000100000000, 64'h1, 1'b1, 3'b000, 3'b111, 6'b010000);

    // Mid-stream asynchronous reset
    apply_lit("pre_reset", 64'h1111, 64'h2222, 1'b1, 3'b010, 3'b000, 6'b000000, 64'h3333);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_clear", bus.result, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold_edge", bus.result, 64'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    apply_lit("post_reset", 64'd10, 64'd3, 1'b1, 3'b000, 3'b000, 6'b010000, 64'h7);

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu.md
# alu

Dual-mode 64-bit integer ALU for the processor execute stage. In unified mode it performs one 64-bit operation. In split mode it performs two independent 32-bit operations, one on each half of the operands. The result is registered: one clock of latency, asynchronous active-low clear.

## Interface
- No parameters; datapath width fixed at 64 bits (two 32-bit lanes).
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- a  input  64  operand A.
- b  input  64  operand B; also supplies shift amounts.
- mode  input  1  1 = unified 64-bit op; 0 = split, two 32-bit lanes.
- ALUOpA  input  3  opcode for the unified op, or for the low lane in split mode.
- ALUOpB  input  3  opcode for the high lane in split mode; ignored when mode=1.
- ALUCtrl  input  6  operation modifiers, decoded below.
- result  output  64  registered result.

## Operation
- Opcode encoding (shared by both fields):
  - 000 ADD/SUB
  - 001 AND
  - 010 OR
  - 011 XOR
  - 100 SHIFT
  - 101–111 produce all-zero for that lane or word.
- Unified mode (mode=1):
  - Op ALUOpA on a[63:0] and b[63:0].
  - ALUCtrl[4]: with ADD, 1 = subtract (a−b); with SHIFT, 1 = arithmetic right shift.
  - ALUCtrl[5]: shift direction, 0 = left, 1 = right.
  - Shift amount is b[5:0].
  - ALUCtrl[5]=0 with [4]=1 is a logical left shift; [4] is ignored for left shifts.
  - ALUCtrl[3:0] ignored.
- Split mode (mode=0):
  - Low lane: ALUOpA on a[31:0] and b[31:0], writing result[31:0].
  - High lane: ALUOpB on a[63:32] and b[63:32], writing result[63:32].
  - ALUCtrl[0] is lo_sub / lo_arith.
  - ALUCtrl[1] is lo_dir (1 = right).
  - ALUCtrl[2] is hi_sub / hi_arith.
  - ALUCtrl[3] is hi_dir.
  - Per-lane shift amount is b[4:0] of that lane's half.
  - ALUCtrl[5:4] ignored.
- Arithmetic: two's-complement, modulo 2^64 (unified) or 2^32 per lane.
  - No carry, borrow or shift bits cross the lane boundary in split mode.
  - No flags are produced.
- Shifts:
  - Logical shifts fill with zeros.
  - Arithmetic right shift fills with the sign bit of the word or lane.
  - A shift amount of 0 passes the operand through unchanged.

## Timing
- The combinational result is captured into the result register on every rising clk edge; there is no enable.
- Latency is 1 cycle: inputs present before edge N appear on result after edge N and hold until edge N+1.
- rst_n low clears result to 0 immediately, independent of clk, and holds it at 0 while low.
- The first capture after reset is at the first rising edge with rst_n high.
- A reset asserted mid-stream discards the in-flight result; no partial state survives.
- Changing mode or opcode takes effect on the very next capture, with no pipeline drain.

## Test plan
- Reset: assert rst_n=0 -> result=0 asynchronously; it stays 0 across clock edges while rst_n is low.
- Unified arithmetic and logic (mode=1, each checked one cycle after apply):
  - a=3, b=4, ADD -> 0x7.
  - a=9, b=5, ALUCtrl=010000 -> 0x4.
  - a=FFFF0000FFFF0000, b=0F0FF0F00F0FF0F0, AND -> 0F0F00000F0F0000.
  - All-ones+1 -> 0.
- Unified shifts (mode=1):
  - a=0xFF, b=4, ALUCtrl=000000 -> 0xFF0.
  - a=8000000000000000, b=4, ALUCtrl=100000 -> 0800000000000000.
  - Same operands, ALUCtrl=110000 -> F800000000000000.
- Split logic (mode=0, a=FFFF0000_DEADBEEF, b=00000004_00000001):
  - lo ADD, hi AND -> 00000000_DEADBEF0.
  - lo OR, hi XOR -> FFFF0004_DEADBEEF.
- Split shift and sub (same operands):
  - Both SHIFT, ALUCtrl=001100 -> FFFFF000_BD5B7DDE.
  - Both ADD, ALUCtrl=000100 -> FFFEFFFC_DEADBEF0.
- Lane isolation: mode=0, a=all ones, b=1, both ADD, ALUCtrl=0 -> FFFFFFFF_00000000 (no carry into the high lane).
